pc_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch for the 32-bit core.
- Issues fetch requests to instruction memory using a req/ack handshake, then presents each fetched instruction to decode/execute for one execute window.
- Selects the next PC from PC+4, branch target, jump target or exception vector.
- Sits between the instruction-memory port and the decode/control stage.

---
 rtl/pc_sequencer_pkg.sv | 28 ++
 rtl/pc_next_select.sv | 47 ++++
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding,
// next-PC select codes, default reset/exception addresses and an alignment helper.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_EXC    = 2'd3
    } pc_sel_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;
    localparam logic [31:0] DEFAULT_PC_STEP    = 32'd4;

    // Instruction addresses must be word aligned; any low bit set is a fault.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_select.sv
// Combinational next-PC selector: jump beats branch beats sequential step,
// and a misaligned redirect target is replaced by the exception vector.
module pc_next_select
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
    parameter logic [31:0] PC_STEP    = DEFAULT_PC_STEP
) (
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    pc_sel_t sel;

    // Pick the source by priority; only redirect targets are alignment-checked,
    // the sequential step from an aligned pc is always aligned.
    always_comb begin
        sel = SEL_SEQ;
        if (jump) begin
            sel = is_misaligned(jump_target) ? SEL_EXC : SEL_JUMP;
        end else if (branch_taken) begin
            sel = is_misaligned(branch_target) ? SEL_EXC : SEL_BRANCH;
        end
    end

    // Turn the select code into the address; the sequential add wraps mod 2^32.
    always_comb begin
        next_pc    = pc + PC_STEP;
        misaligned = 1'b0;
        case (sel)
            SEL_SEQ:    next_pc = pc + PC_STEP;
            SEL_BRANCH: next_pc = branch_target;
            SEL_JUMP:   next_pc = jump_target;
            SEL_EXC: begin
                next_pc    = EXC_VECTOR;
                misaligned = 1'b1;
            end
            default:    next_pc = pc + PC_STEP;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetches each instruction over a req/ack handshake,
// holds it for an execute window, then chooses the next pc.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
    parameter logic [31:0] PC_STEP    = DEFAULT_PC_STEP
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic        exc_misaligned,
    output logic        halted
);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic [31:0] instr_pc_d;
    logic        exc_d;
    logic [31:0] sel_pc;
    logic        sel_misaligned;

    pc_next_select #(
        .EXC_VECTOR (EXC_VECTOR),
        .PC_STEP    (PC_STEP)
    ) u_next_select (
        .pc            (pc),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (sel_pc),
        .misaligned    (sel_misaligned)
    );

    // State register; reset abandons any outstanding fetch immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and next register values; stall freezes EXEC entirely, halt outranks redirects.
    always_comb begin
        state_next = state;
        pc_d       = pc;
        instr_d    = instr;
        instr_pc_d = instr_pc;
        exc_d      = 1'b0;
        case (state)
            IDLE:   state_next = FETCH;
            FETCH: begin
                if (fetch_ack) begin
                    instr_d    = fetch_rdata;
                    instr_pc_d = pc;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (halt) begin
                        state_next = HALTED;
                    end else begin
                        pc_d       = sel_pc;
                        exc_d      = sel_misaligned;
                        state_next = FETCH;
                    end
                end
            end
            HALTED: state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs, all derived from the upcoming state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc             <= RESET_PC;
            instr          <= 32'h0;
            instr_pc       <= 32'h0;
            fetch_req      <= 1'b0;
            instr_valid    <= 1'b0;
            exc_misaligned <= 1'b0;
            halted         <= 1'b0;
        end else begin
            pc             <= pc_d;
            instr          <= instr_d;
            instr_pc       <= instr_pc_d;
            fetch_req      <= (state_next == FETCH);
            instr_valid    <= (state_next == EXEC);
            exc_misaligned <= exc_d;
            halted         <= (state_next == HALTED);
        end
    end

    assign fetch_addr = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

    logic        clock;
    logic        reset_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        exc_misaligned;
    logic        halted;

    int passed = 0;
    int total  = 0;

    pc_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_ack      (fetch_ack),
        .fetch_rdata    (fetch_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .halt           (halt),
        .exc_misaligned (exc_misaligned),
        .halted         (halted)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        else
            passed++;
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic stl,
                                 input logic br, input logic [31:0] bt,
                                 input logic jp, input logic [31:0] jt, input logic hlt);
        fetch_ack     = ack;
        fetch_rdata   = rdata;
        stall         = stl;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        halt          = hlt;
    endtask

    initial begin
        reset_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_fetch_req", {31'b0, fetch_req}, 32'd0);
        checkOutput("rst_fetch_addr", fetch_addr, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        checkOutput("rst_flags", {28'b0, instr_valid, exc_misaligned, halted, fetch_req}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Sequential fetch with immediate acks
        tick();
        checkOutput("idle_to_fetch_req", {31'b0, fetch_req}, 32'd1);
        checkOutput("seq_addr0", fetch_addr, 32'h0);
        checkOutput("seq_valid_low0", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h1111_0000 + 32'(i * 4), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            tick();
            checkOutput("seq_exec_valid", {31'b0, instr_valid}, 32'd1);
            checkOutput("seq_exec_req", {31'b0, fetch_req}, 32'd0);
            checkOutput("seq_instr", instr, 32'h1111_0000 + 32'(i * 4));
            checkOutput("seq_instr_pc", instr_pc, 32'(i * 4));
            tick();
            checkOutput("seq_fetch_req", {31'b0, fetch_req}, 32'd1);
            checkOutput("seq_fetch_addr", fetch_addr, 32'(i * 4 + 4));
            checkOutput("seq_fetch_valid", {31'b0, instr_valid}, 32'd0);
        end

        // Delayed ack at pc=0x10: three idle cycles, ack in the fourth
        applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("wait_req", {31'b0, fetch_req}, 32'd1);
            checkOutput("wait_addr", fetch_addr, 32'h10);
            checkOutput("wait_instr_held", instr, 32'h1111_000C);
            checkOutput("wait_valid", {31'b0, instr_valid}, 32'd0);
        end
        applyStimulus(1'b1, 32'h2222_0010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("late_ack_instr", instr, 32'h2222_0010);
        checkOutput("late_ack_pc", instr_pc, 32'h10);

        // Jump to 0x20, then jump+branch together: jump wins
        applyStimulus(1'b1, 32'h3333_0020, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
        tick();
        checkOutput("jmp20_addr", fetch_addr, 32'h20);
        applyStimulus(1'b1, 32'h3333_0020, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("at20_instr_pc", instr_pc, 32'h20);
        applyStimulus(1'b1, 32'h4444_0100, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
        tick();
        checkOutput("jump_over_branch", fetch_addr, 32'h100);
        checkOutput("jump_no_exc", {31'b0, exc_misaligned}, 32'd0);
        applyStimulus(1'b1, 32'h4444_0100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h5555_0040, 1'b0, 1'b1, 32'h40, 1'b0, 32'h100, 1'b0);
        tick();
        checkOutput("branch_taken_addr", fetch_addr, 32'h40);
        applyStimulus(1'b1, 32'h5555_0040, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("at40_instr", instr, 32'h5555_0040);

        // Misaligned branch target goes to the exception vector
        applyStimulus(1'b1, 32'h6666_0080, 1'b0, 1'b1, 32'h42, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("misalign_pulse", {31'b0, exc_misaligned}, 32'd1);
        checkOutput("misalign_addr", fetch_addr, 32'h80);
        applyStimulus(1'b1, 32'h6666_0080, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("misalign_pulse_end", {31'b0, exc_misaligned}, 32'd0);
        checkOutput("exc_instr_pc", instr_pc, 32'h80);

        // Stall for five cycles with jump held, then release
        applyStimulus(1'b1, 32'h7777_0200, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_valid", {31'b0, instr_valid}, 32'd1);
            checkOutput("stall_pc", fetch_addr, 32'h80);
            checkOutput("stall_instr", instr, 32'h6666_0080);
            checkOutput("stall_req", {31'b0, fetch_req}, 32'd0);
        end
        applyStimulus(1'b1, 32'h7777_0200, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
        tick();
        checkOutput("unstall_jump", fetch_addr, 32'h200);

        // Sequential wrap from 0xFFFF_FFFC
        applyStimulus(1'b1, 32'h8888_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h8888_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        checkOutput("jump_top_addr", fetch_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 32'h8888_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("top_instr_pc", instr_pc, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_addr", fetch_addr, 32'h0);
        checkOutput("wrap_no_exc", {31'b0, exc_misaligned}, 32'd0);
        applyStimulus(1'b1, 32'h9999_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();

        // Halt in EXEC with a jump also present: halt wins and sticks
        applyStimulus(1'b1, 32'h9999_0000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
        tick();
        checkOutput("halted_set", {31'b0, halted}, 32'd1);
        checkOutput("halted_req", {31'b0, fetch_req}, 32'd0);
        checkOutput("halted_valid", {31'b0, instr_valid}, 32'd0);
        applyStimulus(1'b1, 32'h9999_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("halted_stays", {30'b0, halted, fetch_req}, 32'd2);
            checkOutput("halted_pc", fetch_addr, 32'h0);
        end

        // Reset out of HALTED, move pc away from RESET_PC, then reset mid-fetch
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        tick();
        tick();
        checkOutput("rehalt_exec_pc", instr_pc, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
        tick();
        checkOutput("pre_rst_addr", fetch_addr, 32'h400);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("pre_rst_req", {31'b0, fetch_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midfetch_rst_req", {31'b0, fetch_req}, 32'd0);
        checkOutput("midfetch_rst_addr", fetch_addr, 32'h0);
        applyStimulus(1'b1, 32'hBAD0_0400, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("late_ack_in_rst", {31'b0, instr_valid}, 32'd0);
        reset_n = 1'b1;
        applyStimulus(1'b1, 32'hCCCC_0000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("post_rst_addr", fetch_addr, 32'h0);
        checkOutput("post_rst_req", {31'b0, fetch_req}, 32'd1);
        checkOutput("post_rst_instr", instr, 32'h0);
        tick();
        checkOutput("post_rst_exec_instr", instr, 32'hCCCC_0000);
        checkOutput("post_rst_exec_pc", instr_pc, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
